// File: rtl/tracklet_proj_sched.sv
// tracklet_proj_sched: round-robin scheduler that feeds one tracklet-projection
// datapath from N_SRC tracklet-calculator memories. It pops at most one word
// per cycle, enforces a per-event tracklet cap and an event time budget, and
// counts issued-but-not-emerged projections so the datapath drains before the
// next event.
// src_empty/src_data are first-word-fall-through: src_data[i] shows the word
// that src_read[i] pops, and the following word is valid one cycle later.
// Optional statistics (stall_cnt, evt_issued) are built when the macro
// PROJ_SCHED_STATS_EN is defined.
module tracklet_proj_sched #(
    parameter int N_SRC      = 4,
    parameter int DATA_W     = 56,
    parameter int LATENCY    = 16,
    parameter int MAX_TRK    = 64,
    parameter int EVT_CYCLES = 108
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_proc,
    input  logic                      start,
    input  logic [N_SRC-1:0]          src_empty,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_read,
    output logic [DATA_W-1:0]         tracklet,
    output logic                      valid_trackpar,
    output logic [3:0]                TC_index,
    output logic                      proj_start,
    output logic                      busy,
    output logic [4:0]                inflight
`ifdef PROJ_SCHED_STATS_EN
    ,
    output logic [15:0]               stall_cnt,
    output logic [6:0]                evt_issued
`endif
);

    // Last timer value at which a grant may still be made is GRANT_LIMIT-1;
    // the remaining cycles of the event are left for the datapath to drain.
    localparam int GRANT_LIMIT = EVT_CYCLES - LATENCY - 2;
    localparam int PTR_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W       = $clog2(MAX_TRK + 1);
    localparam int TMR_W       = $clog2(GRANT_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [TMR_W-1:0]                timer_q, timer_d;

    logic                            valid_q, valid_d;
    logic [3:0]                      tc_q, tc_d;
    logic [DATA_W-1:0]               trk_q, trk_d;
    logic                            pstart_q;
    logic [LATENCY-1:0]              lat_sr_q, lat_sr_d;
    logic [4:0]                      inflight_q, inflight_d;

    logic [N_SRC-1:0][DATA_W-1:0]    src_words;
    logic [PTR_W-1:0]                cand;
    logic                            gnt_found;
    logic [PTR_W-1:0]                gnt_idx;
    logic                            can_grant;
    logic                            grant;
    logic                            lat_tail;

    assign src_words = src_data;

    // Round-robin search: first non-empty source at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % N_SRC);
            if (!gnt_found && !src_empty[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // A start pulse re-arms the event, so it takes priority over a grant.
    assign can_grant = (state_q == ARB) && !reset && !start && en_proc &&
                       (count_q < CNT_W'(MAX_TRK)) &&
                       (timer_q < TMR_W'(GRANT_LIMIT));
    assign grant     = can_grant && gnt_found;
    assign src_read  = grant ? (N_SRC'(1) << gnt_idx) : '0;

    // Event control: state, timer, per-event count and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            count_d  = count_q + 1'b1;
            rr_ptr_d = PTR_W'((int'(gnt_idx) + 1) % N_SRC);
        end
        if (start) begin
            state_d  = ARB;
            timer_d  = '0;
            count_d  = '0;
            rr_ptr_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                ARB: begin
                    if (timer_q == TMR_W'(GRANT_LIMIT)) begin
                        state_d = DRAIN;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (inflight_q == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Issue stage: capture the granted word and its source index.
    always_comb begin
        valid_d = grant;
        tc_d    = tc_q;
        trk_d   = trk_q;
        if (grant) begin
            tc_d  = 4'(gnt_idx);
            trk_d = src_words[gnt_idx];
        end
    end

    // In-flight accounting: the shift register mirrors the datapath latency.
    assign lat_tail = lat_sr_q[LATENCY-1];
    always_comb begin
        lat_sr_d   = {lat_sr_q[LATENCY-2:0], valid_q};
        inflight_d = inflight_q;
        if (valid_q && !lat_tail) begin
            inflight_d = inflight_q + 5'd1;
        end else if (!valid_q && lat_tail) begin
            inflight_d = inflight_q - 5'd1;
        end
    end

    // State and pipeline registers; start never clears in-flight tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            valid_q    <= 1'b0;
            tc_q       <= '0;
            trk_q      <= '0;
            pstart_q   <= 1'b0;
            lat_sr_q   <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            valid_q    <= valid_d;
            tc_q       <= tc_d;
            trk_q      <= trk_d;
            pstart_q   <= start;
            lat_sr_q   <= lat_sr_d;
            inflight_q <= inflight_d;
        end
    end

    assign tracklet       = trk_q;
    assign valid_trackpar = valid_q;
    assign TC_index       = tc_q;
    assign proj_start     = pstart_q;
    assign inflight       = inflight_q;
    assign busy           = (state_q != IDLE) || (inflight_q != '0);

`ifdef PROJ_SCHED_STATS_EN
    logic [15:0] stall_q;
    logic [6:0]  evt_q;
    logic        stall_hit;

    assign stall_hit = ((state_q == ARB) || (state_q == DRAIN)) &&
                       (|(~src_empty)) && !grant;

    // Stall counter (saturating) and previous-event issue count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            evt_q   <= '0;
        end else if (start) begin
            stall_q <= '0;
            evt_q   <= 7'(count_q);
        end else if (stall_hit && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt  = stall_q;
    assign evt_issued = evt_q;
`endif

endmodule

// File: tb/tb_tracklet_proj_sched.sv
// Bench for tracklet_proj_sched: table of event scenarios with hand-derived
// totals, a few hand-written multi-cycle sequences, and a randomized run, all
// checked every cycle against a queue-based reference model.
module tb_tracklet_proj_sched;
    localparam int N    = 4;
    localparam int W    = 56;
    localparam int LAT  = 16;
    localparam int MAXT = 64;
    localparam int EVT  = 108;
    localparam int LIM  = EVT - LAT - 2;
    localparam int P_IDLE = 0, P_ARB = 1, P_DRAIN = 2;

    logic                 clk = 1'b0;
    logic                 reset, en_proc, start;
    logic [N-1:0]         src_empty, src_read;
    logic [N-1:0][W-1:0]  src_words;
    logic [W-1:0]         tracklet;
    logic                 valid_trackpar, proj_start, busy;
    logic [3:0]           TC_index;
    logic [4:0]           inflight;
`ifdef PROJ_SCHED_STATS_EN
    logic [15:0]          stall_cnt;
    logic [6:0]           evt_issued;
`endif

    always #5 clk = ~clk;

    tracklet_proj_sched #(.N_SRC(N), .DATA_W(W), .LATENCY(LAT), .MAX_TRK(MAXT), .EVT_CYCLES(EVT)) dut (
        .clk(clk), .reset(reset), .en_proc(en_proc), .start(start),
        .src_empty(src_empty), .src_data(src_words), .src_read(src_read),
        .tracklet(tracklet), .valid_trackpar(valid_trackpar), .TC_index(TC_index),
        .proj_start(proj_start), .busy(busy), .inflight(inflight)
`ifdef PROJ_SCHED_STATS_EN
        , .stall_cnt(stall_cnt), .evt_issued(evt_issued)
`endif
    );

    // Source memories and reference model state
    logic [W-1:0] srcq [N][$];
    int           vlog [$];          // cycles in which valid_trackpar was high
    int           m_phase = P_IDLE, m_timer = 0, m_count = 0, m_rr = 0;
    int           m_tc = 0, m_stall = 0, m_evt = 0;
    bit           m_valid = 1'b0, m_pstart = 1'b0;
    logic [W-1:0] m_trk = '0;
    int           cyc = 0;
    int           n_chk = 0, n_fail = 0;
    int           sc_valids, sc_peak, sc_busy;

    typedef struct {
        int w0, w1, w2, w3;
        int off_at, off_len;
        int exp_issued, exp_peak, exp_busy, exp_left2;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [63:0] x;
        x = {$urandom, $urandom};
        return x[W-1:0];
    endfunction

    // Projections in flight during cycle c: those issued within the last LAT cycles.
    function automatic int inflight_at(input int c);
        int n = 0;
        foreach (vlog[j]) if (vlog[j] >= c - LAT && vlog[j] <= c - 1) n++;
        return n;
    endfunction

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            src_empty[i[1:0]] = (srcq[i].size() == 0);
            src_words[i[1:0]] = (srcq[i].size() != 0) ? srcq[i][0] : '0;
        end
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic cycle(input bit st, input bit en);
        int g, inf_now, idx;
        bit any_ne;
        logic [N-1:0] exp_rd, rd_seen;
        logic [W-1:0] tmp;
        start = st; en_proc = en; drive_src();
        #1;
        inf_now = inflight_at(cyc);
        any_ne = 1'b0;
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) any_ne = 1'b1;
        g = -1;
        if (!reset && m_phase == P_ARB && !st && en && m_count < MAXT && m_timer < LIM)
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && srcq[idx].size() != 0) g = idx;
            end
        exp_rd = '0;
        if (g >= 0) exp_rd[g[1:0]] = 1'b1;
        rd_seen = src_read;
        chk("src_read", 64'(src_read), 64'(exp_rd));
        chk("busy", 64'(busy), 64'(m_phase != P_IDLE || inf_now != 0));
        chk("inflight", 64'(inflight), 64'(inf_now));
        sc_busy += int'(busy);
        if (int'(inflight) > sc_peak) sc_peak = int'(inflight);
        if (reset) begin
            m_phase = P_IDLE; m_timer = 0; m_count = 0; m_rr = 0;
            m_valid = 1'b0; m_tc = 0; m_trk = '0; m_pstart = 1'b0;
            vlog.delete(); m_stall = 0; m_evt = 0;
        end else begin
            if (m_valid) vlog.push_back(cyc);
            if (!st && m_phase != P_IDLE && any_ne && g < 0 && m_stall < 65535) m_stall++;
            m_pstart = st;
            m_valid  = (g >= 0);
            if (g >= 0) begin
                m_tc = g; m_trk = srcq[g][0]; m_count++; m_rr = (g + 1) % N;
            end
            if (st) begin
                m_evt = m_count; m_phase = P_ARB; m_timer = 0; m_count = 0; m_rr = 0; m_stall = 0;
            end else if (m_phase == P_ARB) begin
                if (m_timer == LIM) m_phase = P_DRAIN; else m_timer++;
            end else if (m_phase == P_DRAIN) begin
                if (inf_now == 0) m_phase = P_IDLE;
            end
        end
        @(posedge clk); #1;
        cyc++;
        while (vlog.size() > 0 && vlog[0] < cyc - LAT) tmp = W'(vlog.pop_front());
        for (int i = 0; i < N; i++)
            if (rd_seen[i[1:0]] && srcq[i].size() != 0) tmp = srcq[i].pop_front();
        chk("valid_trackpar", 64'(valid_trackpar), 64'(m_valid));
        if (m_valid) chk("TC_index", 64'(TC_index), 64'(m_tc));
        chk("tracklet", 64'(tracklet), 64'(m_trk));
        chk("proj_start", 64'(proj_start), 64'(m_pstart));
`ifdef PROJ_SCHED_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("evt_issued", 64'(evt_issued), 64'(m_evt));
`endif
        sc_valids += int'(valid_trackpar);
        drive_src();
    endtask

    task automatic fill(input int s, input int n);
        for (int k = 0; k < n; k++) srcq[s].push_back(rand_word());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // {words per source}, en_proc-low window (relative to start), expected totals
        tbl[0] = '{0, 0, 0, 0,     0,  0,  0,  0,  92, 0};
        tbl[1] = '{3, 3, 3, 3,     0,  0, 12, 12,  92, 0};
        tbl[2] = '{0, 0, 70, 0,    0,  0, 64, 16,  92, 6};
        tbl[3] = '{20, 20, 20, 20, 10, 5, 64, 16,  92, 4};
        tbl[4] = '{1, 0, 5, 2,     0,  0,  8,  8,  92, 0};
        tbl[5] = '{30, 30, 30, 30, 1, 60, 30, 16, 108, 23};

        reset = 1'b1; start = 1'b0; en_proc = 1'b0;
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        cycle(1'b0, 1'b1);
        chk("rst_valid", 64'(valid_trackpar), 64'd0);
        chk("rst_tracklet", 64'(tracklet), 64'd0);
        chk("rst_tc", 64'(TC_index), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        reset = 1'b0;
        cycle(1'b0, 1'b1);

        // Table-driven event scenarios
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) srcq[i].delete();
            fill(0, tbl[t].w0); fill(1, tbl[t].w1); fill(2, tbl[t].w2); fill(3, tbl[t].w3);
            sc_valids = 0; sc_peak = 0; sc_busy = 0;
            for (int r = 0; r < 120; r++)
                cycle(r == 0, !(r >= tbl[t].off_at && r < tbl[t].off_at + tbl[t].off_len));
            chk("tbl_issued", 64'(sc_valids), 64'(tbl[t].exp_issued));
            chk("tbl_peak_inflight", 64'(sc_peak), 64'(tbl[t].exp_peak));
            chk("tbl_busy_cycles", 64'(sc_busy), 64'(tbl[t].exp_busy));
            chk("tbl_src2_left", 64'(srcq[2].size()), 64'(tbl[t].exp_left2));
        end

        // Restart while 10 projections are in flight
        for (int i = 0; i < N; i++) srcq[i].delete();
        fill(0, 40); fill(1, 40); fill(2, 40);
        cycle(1'b1, 1'b1);
        for (int r = 1; r <= 10; r++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("restart_proj_start", 64'(proj_start), 64'd1);
        chk("restart_inflight", 64'(inflight), 64'd10);
        cycle(1'b0, 1'b1);
        chk("restart_valid", 64'(valid_trackpar), 64'd1);
        chk("restart_rr_tc", 64'(TC_index), 64'd0);
        chk("restart_inflight_hold", 64'(inflight), 64'd10);
        for (int r = 0; r < 110; r++) cycle(1'b0, 1'b1);

        // Randomized traffic: starts mid-ARB/mid-DRAIN, en_proc gaps, rare resets
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) fill(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
            reset = ($urandom_range(0, 999) == 0);
            cycle($urandom_range(0, 79) == 0, $urandom_range(0, 9) != 0);
        end
        reset = 1'b0;
        cycle(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
